audio_i2s_ctrl: RTL
===================

# audio_i2s_ctrl

Sequencer for the board's I2S audio DAC/amplifier path. It replaces free-running integer clock division with a fractional phase accumulator, so the average sample rate is exact. It buffers one stereo sample from the core through a valid/ready handshake and serializes it MSB-first in standard I2S format (one-bit WS delay). It sits in the board top level between the core's 16-bit stereo audio output and the `hp_bck`/`hp_ws`/`hp_din`/`pa_en` pins, clocked by `clk32`.

## Interface
Parameters:
- `CLK_HZ`, 32000000, frequency of `clk32`.
- `SAMPLE_HZ`, 48000, stereo frame rate. Requirement: `64*SAMPLE_HZ < CLK_HZ`.

Ports:
- `clk32`, in, 1: the block's single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_l`, in, 16: left sample, two's complement.
- `in_r`, in, 16: right sample, two's complement.
- `in_valid`, in, 1: a sample pair is offered.
- `in_ready`, out, 1: the holding register is empty.
- `mute`, in, 1: when 1, zeros are transmitted in place of the sample data.
- `hp_bck`, out, 1: I2S bit clock.
- `hp_ws`, out, 1: word select; 0 = left, 1 = right.
- `hp_din`, out, 1: serial data.
- `pa_en`, out, 1: amplifier enable.
- `underrun`, out, 1: one-cycle pulse when a frame starts with no new sample.
- `underrun_cnt`, out, 16: saturating underrun count (see Configuration).

## Operation
- Phase accumulator `acc`, 27 bits, with `INC = 64*SAMPLE_HZ`.
  - Each cycle: if `acc + INC >= CLK_HZ`, then `acc <= acc + INC - CLK_HZ` and `hp_bck` toggles; otherwise `acc <= acc + INC`.
- Falling edge of `hp_bck` (the cycle in which it toggles 1→0) is the "fall" event. All other state advances only on fall.
- Slot counter `slot`, 5 bits, increments on each fall and wraps 31→0.
- Data mapping:
  - Slots 0..15 carry `L[15..0]`.
  - Slots 16..31 carry `R[15..0]`.
- Word select: `hp_ws` = 1 in slots 15..30 and 0 in slots 31 and 0..14. WS therefore leads the data by one bit.
- Frame shift register `sh`, 32 bits; `hp_din = sh[31]`.
  - On fall entering slot 0: load `sh`, or load zeros if `mute`.
  - On every other fall: `sh <= {sh[30:0],1'b0}`.
- Load source selection on the fall entering slot 0:
  - Holding register full: load it and clear it.
  - Holding register empty and `in_valid` high in that same cycle: bypass, loading `{in_l,in_r}` directly. No underrun.
  - Otherwise: reload the last transmitted pair (the mute-independent copy `last`), pulse `underrun`, and increment the counter.
- Handshake:
  - `in_ready = ~full`.
  - Transfer occurs on `in_valid & in_ready`; the holding register becomes full on the next cycle.
  - The source may hold `in_valid` high continuously; at most one transfer per frame is accepted once the register is full.
- `pa_en` is set on the first fall entering slot 0 that loads real data (holding register or bypass). It then stays 1 until reset.

## Timing
- Reset values:
  - Outputs: `hp_bck`=0, `hp_ws`=0, `hp_din`=0, `pa_en`=0, `underrun`=0, `underrun_cnt`=0, `in_ready`=1.
  - Internal state: `acc`=0, `slot`=31, `sh`=0, `last`=0, holding register empty.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). The first fall after release enters slot 0.
- Bit clock:
  - Half-period is ⌊CLK_HZ/INC⌋ or that value +1 cycles; at defaults, 10 or 11 `clk32` cycles.
  - Long-run rate is exact: 3 frames = 2000 `clk32` cycles at defaults.
- All outputs are registered. `hp_ws` and `hp_din` change only in the fall cycle, so they are stable across the following rising edge of `hp_bck`.
- Latency:
  - A sample accepted during frame N is transmitted in frame N+1.
  - A bypass sample is transmitted starting at the same fall.
- `underrun` is high for exactly one `clk32` cycle, coincident with the fall that enters slot 0.

## Configuration
- `AUDIO_I2S_UNDERRUN_CNT_EN`:
  - Defined: `underrun_cnt` increments on each `underrun` pulse and saturates at 16'hFFFF.
  - Undefined: `underrun_cnt` is tied to 0 and no counter logic is generated.
- `underrun` behaves identically in both cases.

## Test plan
- Reset release with no input: over 2000 cycles, `hp_bck` shows exactly 96 rising edges, each high/low phase lasts 10–11 cycles, and `hp_ws` has a 32-bit period with WS high in slots 15..30.
- Single transfer of `in_l`=16'hA55A, `in_r`=16'h0F0F before the first slot-0 fall: sampling on `hp_bck` rise yields 1010010101011010 then 0000111100001111. `pa_en` rises on the same fall that loads the data.
- Hold `in_valid`=1 continuously with incrementing data: exactly one transfer per frame, no `underrun` pulses, `in_ready` low between accept and load.
- Stop supplying data after the pair 16'h1234/16'h5678: the next frame repeats 1234/5678, `underrun` pulses once per frame, and `underrun_cnt` reads 1, 2, 3 when the macro is defined and stays 0 when it is undefined.
- `mute`=1 with valid data flowing: `hp_din` stays 0 while handshakes continue. Releasing `mute` transmits the next frame's data normally.
- Assert `reset` in slot 20 of a frame: all outputs return to reset values within the same cycle. After release, the first frame starts at slot 0 and WS is low.

Source files
------------

// File: rtl/audio_i2s_ctrl.sv
// I2S sequencer: fractional bit-clock generator, one-deep stereo holding register, MSB-first serializer.
// Optional saturating underrun counter enabled by defining AUDIO_I2S_UNDERRUN_CNT_EN.
module audio_i2s_ctrl #(
    parameter int CLK_HZ    = 32000000,
    parameter int SAMPLE_HZ = 48000
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic [15:0] in_l,
    input  logic [15:0] in_r,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mute,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din,
    output logic        pa_en,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    localparam logic [27:0] INC  = 28'(64 * SAMPLE_HZ);
    localparam logic [27:0] CLKC = 28'(CLK_HZ);

    logic [26:0] acc;
    logic [27:0] acc_sum;
    logic [26:0] acc_wrap;
    logic        tick;
    logic        fall;
    logic        frame_start;
    logic [4:0]  slot;
    logic [4:0]  slot_next;
    logic [31:0] sh;
    logic [31:0] last;
    logic [31:0] hold;
    logic [31:0] load_src;
    logic        full;
    logic        have_data;
    logic        accept;

    function automatic logic ws_for_slot(input logic [4:0] s);
        return (s >= 5'd15) && (s <= 5'd30);
    endfunction

    always_comb begin
        acc_sum     = {1'b0, acc} + INC;
        acc_wrap    = 27'(acc_sum - CLKC);
        tick        = (acc_sum >= CLKC);
        fall        = tick & hp_bck;
        slot_next   = slot + 5'd1;
        frame_start = fall & (slot_next == 5'd0);
        have_data   = full | in_valid;
        // Holding register wins; an empty register with a live offer bypasses straight to the shifter.
        load_src    = full ? hold : (in_valid ? {in_l, in_r} : last);
        // A bypassed offer is consumed by the shifter, so it must not also land in the holding register.
        accept      = in_valid & ~full & ~frame_start;
    end

    assign in_ready = ~full;
    assign hp_din   = sh[31];

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            acc      <= '0;
            hp_bck   <= 1'b0;
            slot     <= 5'd31;
            hp_ws    <= 1'b0;
            sh       <= '0;
            last     <= '0;
            full     <= 1'b0;
            pa_en    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            acc      <= tick ? acc_wrap : acc_sum[26:0];
            underrun <= frame_start & ~have_data;
            if (tick) begin
                hp_bck <= ~hp_bck;
            end
            if (fall) begin
                slot  <= slot_next;
                hp_ws <= ws_for_slot(slot_next);
                if (frame_start) begin
                    sh   <= mute ? '0 : load_src;
                    last <= load_src;
                    if (have_data) begin
                        pa_en <= 1'b1;
                    end
                end else begin
                    sh <= {sh[30:0], 1'b0};
                end
            end
            if (frame_start && full) begin
                full <= 1'b0;
            end else if (accept) begin
                full <= 1'b1;
            end
        end
    end

    // Payload only; its validity is carried by full.
    always_ff @(posedge clk32) begin
        if (accept) begin
            hold <= {in_l, in_r};
        end
    end

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (frame_start && !have_data) begin
            underrun_cnt <= sat_inc(underrun_cnt);
        end
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule
